// File: rtl/feature_frame_buffer.sv
// Collects NUM_FRAMES (mean, std) pairs into one feature vector for the classifier,
// either as a one-shot fill/hold buffer or as a sliding window of the newest pairs.
module feature_frame_buffer #(
  parameter int DATA_W     = 16,
  parameter int NUM_FRAMES = 13,
  parameter int SLIDING    = 0,
  parameter int CNT_W      = $clog2(NUM_FRAMES + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_W-1:0]                mean_in,
  input  logic [DATA_W-1:0]                std_in,
  output logic [2*NUM_FRAMES*DATA_W-1:0]   out_vec,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [CNT_W-1:0]                 frame_count,
  output logic                             overflow
);

  localparam int               NUM_WORDS = 2 * NUM_FRAMES;
  localparam logic [CNT_W-1:0] LAST_WP   = CNT_W'(NUM_FRAMES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(NUM_FRAMES);

  typedef enum logic {ST_FILL, ST_FULL} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] vec_q [NUM_WORDS];
  logic [DATA_W-1:0] vec_d [NUM_WORDS];
  logic [CNT_W-1:0]  wp_q, wp_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              accept;
  logic              handshake;

  // Sliding mode never stalls the producer; one-shot mode stalls while holding a full vector.
  assign in_ready  = !rst && !clear && ((SLIDING != 0) || (state_q == ST_FILL));
  assign accept    = in_valid && in_ready;
  assign handshake = valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    count_d = count_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    vec_d   = vec_q;

    if (SLIDING != 0) begin
      if (handshake) begin
        valid_d = 1'b0;
      end
      if (accept) begin
        for (int k = 0; k < NUM_WORDS - 2; k++) begin
          vec_d[k] = vec_q[k + 2];
        end
        vec_d[NUM_WORDS - 2] = mean_in;
        vec_d[NUM_WORDS - 1] = std_in;
        if (count_q != FULL_CNT) begin
          count_d = count_q + 1'b1;
        end
        // A full window is pending again; losing an unconsumed one is an overflow.
        if (count_d == FULL_CNT) begin
          valid_d = 1'b1;
          if (valid_q && !handshake) begin
            ovf_d = 1'b1;
          end
        end
      end
    end else begin
      case (state_q)
        ST_FILL: begin
          if (accept) begin
            for (int k = 0; k < NUM_FRAMES; k++) begin
              if (wp_q == CNT_W'(k)) begin
                vec_d[2*k]     = mean_in;
                vec_d[2*k + 1] = std_in;
              end
            end
            wp_d    = wp_q + 1'b1;
            count_d = count_q + 1'b1;
            if (wp_q == LAST_WP) begin
              state_d = ST_FULL;
              valid_d = 1'b1;
            end
          end
        end
        default: begin
          // in_ready is low here, so any offered pair is dropped.
          if (in_valid) begin
            ovf_d = 1'b1;
          end
          if (handshake) begin
            state_d = ST_FILL;
            wp_d    = '0;
            count_d = '0;
            valid_d = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q <= ST_FILL;
      wp_q    <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < NUM_WORDS; k++) begin
        vec_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      count_q <= count_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      vec_q   <= vec_d;
    end
  end

  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_out
    assign out_vec[gi*DATA_W +: DATA_W] = vec_q[gi];
  end

  assign out_valid   = valid_q;
  assign frame_count = count_q;
  assign overflow    = ovf_q;

endmodule

// File: doc/feature_frame_buffer.md
Name: feature_frame_buffer

Overview:
- Parametrised successor to the fixed 26-entry mean/std fifo at the end of the audio-processing chain.
- Collects NUM_FRAMES (mean, std) pairs from mean_std into one feature vector for the classifier.
- Adds a valid/ready output handshake, a selectable one-shot or sliding-window mode, a synchronous clear and a sticky overflow flag.

Parameters:
DATA_W, 16, width of each mean/std word
NUM_FRAMES, 13, number of (mean, std) pairs per vector; vector length is 2*NUM_FRAMES
SLIDING, 0, 0 = one-shot fill/hold mode; 1 = sliding-window mode
CNT_W, $clog2(NUM_FRAMES+1), width of frame_count

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active high
clear  in  1  synchronous flush; same effect as rst on all state, including overflow
in_valid  in  1  mean_in/std_in carry a new pair
in_ready  out  1  buffer accepts a pair this cycle
mean_in  in  DATA_W  per-frame mean
std_in  in  DATA_W  per-frame standard deviation
out_vec  out  DATA_W x 2*NUM_FRAMES  feature vector; [2k]=mean, [2k+1]=std of frame k; k=0 is oldest
out_valid  out  1  out_vec holds a complete, unconsumed vector
out_ready  in  1  consumer takes out_vec
frame_count  out  CNT_W  pairs currently held; saturates at NUM_FRAMES
overflow  out  1  sticky: an input pair was dropped, or an unconsumed window was overwritten

Behaviour:
- Accept: in_valid && in_ready. Output handshake: out_valid && out_ready.
- All outputs are registered except in_ready.
- Reset and clear: out_vec all zero, out_valid=0, frame_count=0, overflow=0, write pointer=0, state FILL.
- Clear has priority over any accept or handshake in the same cycle.
- in_ready = !rst && !clear && (SLIDING || state==FILL).
- One-shot mode (SLIDING=0):
  - FILL: an accept writes pair to entries [2*wp], [2*wp+1], then wp++ and frame_count++. An accept with wp==NUM_FRAMES-1 moves to FULL.
  - Transition to FULL: out_valid rises the cycle after the final accept (latency 1).
  - FULL: in_ready=0; out_vec and out_valid are held stable. in_valid while in FULL drops the pair and sets overflow.
  - Handshake in FULL: next state FILL, wp=0, frame_count=0, out_valid=0. out_vec keeps old contents until overwritten entry by entry.
- Sliding mode (SLIDING=1):
  - in_ready=1 always, except during rst/clear.
  - Accept shifts the vector down one pair: entries k get k+1, entry 0 is discarded, new pair goes to entry NUM_FRAMES-1. frame_count increments, saturating at NUM_FRAMES.
  - An accept that leaves frame_count==NUM_FRAMES sets pending; out_valid=pending. Latency is 1 cycle after the accept.
  - Handshake clears pending.
  - Accept while pending=1 with no handshake that cycle: vector updates and overflow is set (unconsumed window lost).
  - Accept and handshake in the same cycle: pending stays 1, no overflow. The consumer takes the pre-update vector.
  - Before the window first fills, out_valid stays 0 and partially shifted contents are visible on out_vec.
- overflow clears only on rst or clear.
- Arithmetic: no data arithmetic; words are stored verbatim. wp and frame_count never exceed NUM_FRAMES.
- Reset mid-fill or mid-hold discards all partial data.
- Accepting a pair in the same cycle as reset deasserts is impossible, because in_ready=0 while rst is high.

Test Plan:
1. SLIDING=0, NUM_FRAMES=13, feed pairs (mean=i, std=100+i) for i=0..12, out_ready=0 -> out_valid=1 one cycle after the 13th accept; out_vec[0]=0, [1]=100, [24]=12, [25]=112; frame_count=13; in_ready=0.
2. Continue scenario 1: in_valid pulse while FULL, then out_ready=1 -> overflow=1 and out_vec unchanged by the dropped pair; the cycle after the handshake, out_valid=0, frame_count=0, in_ready=1.
3. SLIDING=1, NUM_FRAMES=4, feed means 1..6 with out_ready=1 held -> out_valid first rises after mean 4; after mean 6, means in out_vec = {3,4,5,6}; overflow=0.
4. SLIDING=1, window full, out_ready=0, two further accepts -> overflow=1 after the second; then out_ready=1 gives one handshake, out_valid drops, overflow stays 1.
5. Assert clear in the same cycle as an accept with pending=1 -> next cycle all out_vec=0, frame_count=0, out_valid=0, overflow=0; the pair is not stored.
6. Assert rst with 7 pairs loaded in one-shot mode -> all outputs reach reset values; after release, 13 new pairs produce a vector containing none of the old data.
